// File: rtl/debug_tx_pkg.sv
// Shared types and frame-geometry constants for the debug frame transmitter.
// Optional build macro: DEBUG_TX_CHECKSUM_EN adds a trailing XOR checksum byte.
package debug_tx_pkg;

   typedef enum logic [1:0] {IDLE, SEND, DONE} top_state_t;
   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

`ifdef DEBUG_TX_CHECKSUM_EN
   localparam int CHK_BYTES = 1;
`else
   localparam int CHK_BYTES = 0;
`endif

   // Sync byte + sequence number + port bytes (+ checksum).
   function automatic int frame_bytes(input int num_ports);
      return num_ports + 2 + CHK_BYTES;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a registered txd; ready is also raised in the last
// stop-bit cycle so consecutive bytes leave with no idle gap.
module uart_tx_byte
   import debug_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       valid,
   input  logic [7:0] data,
   output logic       ready,
   output logic       txd
);

   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   byte_state_t state_reg, state_next;
   logic [15:0] baud_reg, baud_next;
   logic [2:0]  bit_reg, bit_next;
   logic [7:0]  shift_reg, shift_next;
   logic        txd_reg, txd_next;
   logic        last_baud;

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_reg <= B_IDLE;
         baud_reg  <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
         txd_reg   <= 1'b1;
      end else begin
         state_reg <= state_next;
         baud_reg  <= baud_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
         txd_reg   <= txd_next;
      end
   end

   always_comb begin
      last_baud  = (baud_reg == BAUD_LAST);
      ready      = (state_reg == B_IDLE) || ((state_reg == B_STOP) && last_baud);
      state_next = state_reg;
      baud_next  = last_baud ? '0 : baud_reg + 16'd1;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      txd_next   = txd_reg;

      case (state_reg)
         B_IDLE: baud_next = '0;
         B_START: begin
            if (last_baud) begin
               state_next = B_DATA;
               bit_next   = 3'd0;
               txd_next   = shift_reg[0];
            end
         end
         B_DATA: begin
            if (last_baud) begin
               if (bit_reg == 3'd7) begin
                  state_next = B_STOP;
                  txd_next   = 1'b1;
               end else begin
                  bit_next   = bit_reg + 3'd1;
                  shift_next = {1'b0, shift_reg[7:1]};
                  txd_next   = shift_reg[1];
               end
            end
         end
         B_STOP: begin
            if (last_baud) state_next = B_IDLE;
         end
         default: state_next = B_IDLE;
      endcase

      // A new byte may start straight out of the final stop-bit cycle.
      if (ready && valid) begin
         state_next = B_START;
         shift_next = data;
         baud_next  = '0;
         txd_next   = 1'b0;
      end
   end

   assign txd = txd_reg;

endmodule

// File: rtl/debug_frame_tx.sv
// Snapshots the CPU debug ports and sends them as one framed UART burst.
// Optional build macro: DEBUG_TX_CHECKSUM_EN appends XOR(seq, ports) to each frame.
module debug_frame_tx
   import debug_tx_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 434,
   parameter int         NUM_PORTS    = 7,
   parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
   input  logic                   clk,
   input  logic                   nreset,
   input  logic                   snap_i,
   input  logic [8*NUM_PORTS-1:0] ports_i,
   output logic                   txd_o,
   output logic                   busy_o,
   output logic                   frame_done_o,
   output logic [7:0]             drop_cnt_o
);

   localparam int FRAME_BYTES = frame_bytes(NUM_PORTS);
   localparam int IDX_W       = $clog2(FRAME_BYTES + 1);
   localparam int SLOTS       = 2 ** IDX_W;
   localparam logic [IDX_W-1:0] END_IDX = IDX_W'(FRAME_BYTES);

   top_state_t             state_reg, state_next;
   logic [8*NUM_PORTS-1:0] buf_reg, buf_next;
   logic [IDX_W-1:0]       idx_reg, idx_next;
   logic [7:0]             seq_reg, seq_next;
   logic [7:0]             drop_reg, drop_next;
   logic                   accept;
   logic                   tx_valid, tx_ready;
   logic [7:0]             tx_data;
   logic [7:0]             byte_slot [SLOTS];
`ifdef DEBUG_TX_CHECKSUM_EN
   logic [7:0]             chk_reg, chk_next;
`endif

   // Frame byte lookup by index; slots past the frame end read as zero.
   for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi == 0) begin : g_sync
         assign byte_slot[gi] = SYNC_BYTE;
      end else if (gi == 1) begin : g_seq
         assign byte_slot[gi] = seq_reg;
      end else if (gi < NUM_PORTS + 2) begin : g_port
         assign byte_slot[gi] = buf_reg[(gi-2)*8 +: 8];
      end
`ifdef DEBUG_TX_CHECKSUM_EN
      else if (gi == NUM_PORTS + 2) begin : g_chk
         assign byte_slot[gi] = chk_reg;
      end
`endif
      else begin : g_pad
         assign byte_slot[gi] = 8'h00;
      end
   end

   assign tx_data  = byte_slot[idx_reg];
   assign tx_valid = (state_reg == SEND) && (idx_reg != END_IDX);

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte (
      .clk    (clk),
      .nreset (nreset),
      .valid  (tx_valid),
      .data   (tx_data),
      .ready  (tx_ready),
      .txd    (txd_o)
   );

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_reg <= IDLE;
         buf_reg   <= '0;
         idx_reg   <= '0;
         seq_reg   <= '0;
         drop_reg  <= '0;
`ifdef DEBUG_TX_CHECKSUM_EN
         chk_reg   <= '0;
`endif
      end else begin
         state_reg <= state_next;
         buf_reg   <= buf_next;
         idx_reg   <= idx_next;
         seq_reg   <= seq_next;
         drop_reg  <= drop_next;
`ifdef DEBUG_TX_CHECKSUM_EN
         chk_reg   <= chk_next;
`endif
      end
   end

   always_comb begin
      state_next = state_reg;
      buf_next   = buf_reg;
      idx_next   = idx_reg;
      seq_next   = seq_reg;
      drop_next  = drop_reg;
      accept     = 1'b0;
`ifdef DEBUG_TX_CHECKSUM_EN
      chk_next   = chk_reg;
`endif

      case (state_reg)
         IDLE: accept = snap_i;
         SEND: begin
            if (snap_i && (drop_reg != 8'hFF)) drop_next = drop_reg + 8'd1;
            if (tx_valid && tx_ready) begin
               idx_next = idx_reg + 1'b1;
`ifdef DEBUG_TX_CHECKSUM_EN
               if (idx_reg != '0) chk_next = chk_reg ^ tx_data;
`endif
            end else if ((idx_reg == END_IDX) && tx_ready) begin
               // Last stop bit is on the wire this cycle.
               state_next = DONE;
            end
         end
         DONE: begin
            seq_next   = seq_reg + 8'd1;
            accept     = snap_i;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      if (accept) begin
         buf_next   = ports_i;
         idx_next   = '0;
         state_next = SEND;
`ifdef DEBUG_TX_CHECKSUM_EN
         chk_next   = 8'h00;
`endif
      end
   end

   assign busy_o       = (state_reg != IDLE);
   assign frame_done_o = (state_reg == DONE);
   assign drop_cnt_o   = drop_reg;

endmodule
